pipe_stage_buf: RTL



---
 rtl/pipe_stage_buf.sv | 72 +++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer for the register-writeback payload (wd, wreg, wdata).
// Valid/ready on both sides, global pause via rdy, synchronous squash via flush.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int WD_W   = 5,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WD_W-1:0]            in_wd,
  input  logic                       in_wreg,
  input  logic [DATA_W-1:0]          in_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WD_W-1:0]            out_wd,
  output logic                       out_wreg,
  output logic [DATA_W-1:0]          out_wdata,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WD_W-1:0]   mem_wd    [DEPTH];
  logic              mem_wreg  [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Ready depends only on registered count, so a pop never frees a slot in the same cycle.
  assign in_ready  = rdy && (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && rdy && !flush;
  assign occupancy = count;

  // Empty buffer presents a NOP bubble rather than stale storage.
  assign out_wd    = out_valid ? mem_wd[rd_ptr]    : '0;
  assign out_wreg  = out_valid ? mem_wreg[rd_ptr]  : 1'b0;
  assign out_wdata = out_valid ? mem_wdata[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_wd[wr_ptr]    <= in_wd;
      mem_wreg[wr_ptr]  <= in_wreg;
      mem_wdata[wr_ptr] <= in_wdata;
    end
  end

endmodule
